// File: rtl/noc_packet_sink.sv
// NoC packet sink: accepts header/body/tail flits addressed to this node and reports source, body length and body XOR.
// Optional feature macro NOC_SINK_CHECKSUM_EN enables the body XOR accumulator; without it rpt_csum is tied to zero.
module noc_packet_sink #(
    parameter int DATA_W   = 64,
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int X_ID     = 0,
    parameter int Y_ID     = 0,
    parameter int MAX_BODY = 8
) (
    input  logic              noc_clk,
    input  logic              noc_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W+1:0] in_flit,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [X_W-1:0]    rpt_src_x,
    output logic [Y_W-1:0]    rpt_src_y,
    output logic [7:0]        rpt_len,
    output logic [DATA_W-1:0] rpt_csum,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       err_cnt
);

    localparam int MARK_LO = DATA_W - 4;
    localparam int SRCX_LO = MARK_LO - X_W;
    localparam int SRCY_LO = SRCX_LO - Y_W;
    localparam int DSTX_LO = SRCY_LO - X_W;
    localparam int DSTY_LO = DSTX_LO - Y_W;

    localparam logic [3:0]     HEAD_MARK = 4'hA;
    localparam logic [3:0]     TAIL_MARK = 4'h5;
    localparam logic [X_W-1:0] OWN_X     = X_W'(X_ID);
    localparam logic [Y_W-1:0] OWN_Y     = Y_W'(Y_ID);
    localparam logic [7:0]     MAX_LEN   = 8'(MAX_BODY);

    typedef enum logic [1:0] {IDLE, BODY, DROP, REPORT} state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    srcX_q, srcX_d;
    logic [Y_W-1:0]    srcY_q, srcY_d;
    logic [7:0]        len_q, len_d;
    logic [15:0]       pktCnt_q, errCnt_q;

    logic              isHeader, isTail, fire;
    logic [DATA_W-1:0] payload;
    logic [3:0]        marker;
    logic [X_W-1:0]    srcX, dstX;
    logic [Y_W-1:0]    srcY, dstY;
    logic              dstOk, hdrOk, tailOk;
    logic              hdrLatch, bodyAccept, pktInc, errInc;

    assign isHeader = in_flit[DATA_W+1];
    assign isTail   = in_flit[DATA_W];
    assign payload  = in_flit[DATA_W-1:0];
    assign marker   = payload[DATA_W-1:MARK_LO];
    assign srcX     = payload[SRCX_LO +: X_W];
    assign srcY     = payload[SRCY_LO +: Y_W];
    assign dstX     = payload[DSTX_LO +: X_W];
    assign dstY     = payload[DSTY_LO +: Y_W];

    assign fire   = in_valid && in_ready;
    assign dstOk  = (dstX == OWN_X) && (dstY == OWN_Y);
    assign hdrOk  = (marker == HEAD_MARK) && dstOk;
    assign tailOk = (marker == TAIL_MARK) && dstOk && (srcX == srcX_q) && (srcY == srcY_q);

    // A header is judged identically in IDLE, DROP and BODY; BODY additionally charges one error for the abandoned packet.
    always_comb begin
        state_d    = state_q;
        srcX_d     = srcX_q;
        srcY_d     = srcY_q;
        len_d      = len_q;
        hdrLatch   = 1'b0;
        bodyAccept = 1'b0;
        pktInc     = 1'b0;
        errInc     = 1'b0;
        unique case (state_q)
            IDLE, DROP, BODY: begin
                if (fire && isHeader) begin
                    errInc = (state_q == BODY) || isTail || !hdrOk;
                    if (isTail) begin
                        state_d = IDLE;
                    end else if (!hdrOk) begin
                        state_d = DROP;
                    end else begin
                        state_d  = BODY;
                        hdrLatch = 1'b1;
                        srcX_d   = srcX;
                        srcY_d   = srcY;
                        len_d    = '0;
                    end
                end else if (fire && state_q == IDLE) begin
                    errInc = 1'b1;
                end else if (fire && state_q == DROP) begin
                    if (isTail) state_d = IDLE;
                end else if (fire) begin
                    if (isTail) begin
                        if (tailOk) begin
                            state_d = REPORT;
                            pktInc  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            errInc  = 1'b1;
                        end
                    end else if (len_q == MAX_LEN) begin
                        state_d = DROP;
                        errInc  = 1'b1;
                    end else begin
                        bodyAccept = 1'b1;
                        len_d      = len_q + 8'd1;
                    end
                end
            end
            REPORT: begin
                if (rpt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q  <= IDLE;
            srcX_q   <= '0;
            srcY_q   <= '0;
            len_q    <= '0;
            pktCnt_q <= '0;
            errCnt_q <= '0;
        end else begin
            state_q <= state_d;
            srcX_q  <= srcX_d;
            srcY_q  <= srcY_d;
            len_q   <= len_d;
            if (pktInc && pktCnt_q != 16'hFFFF) pktCnt_q <= pktCnt_q + 16'd1;
            if (errInc && errCnt_q != 16'hFFFF) errCnt_q <= errCnt_q + 16'd1;
        end
    end

`ifdef NOC_SINK_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (hdrLatch) csum_d = '0;
        else if (bodyAccept) csum_d = csum_q ^ payload;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) csum_q <= '0;
        else csum_q <= csum_d;
    end

    assign rpt_csum = csum_q;
`else
    logic unusedBits;
    assign unusedBits = ^{payload, hdrLatch, bodyAccept};
    assign rpt_csum   = '0;
`endif

    assign in_ready  = (state_q != REPORT);
    assign rpt_valid = (state_q == REPORT);
    assign rpt_src_x = srcX_q;
    assign rpt_src_y = srcY_q;
    assign rpt_len   = len_q;
    assign pkt_cnt   = pktCnt_q;
    assign err_cnt   = errCnt_q;

endmodule
